ball_collision: RTL and testbench
=================================

BALL_COLLISION -- requirements
Module: ball_collision

Interface
REQ-001 Parameters (name, default, meaning): BALL_R, 8, ball half-size; OBS_H, 8, obstacle half-size in x; OBS_W, 32, obstacle half-size in y; Y_MIN, 84, lowest ball/obstacle y; X_MAX, 479, obstacle exit row; SPAWN_PERIOD, 64, frame ticks between spawns; HIT_FRAMES, 32, recovery frames; LIVES_INIT, 3, lives per game.
REQ-002 clk  in  1  system clock; the block is in a single clock domain.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  level input; a new game begins on a cycle where it is high in IDLE or OVER.
REQ-005 frame_tick  in  1  one-cycle pulse, once per frame.
REQ-006 x_ball  in  9  ball row from the position block; y_ball  in  10  ball column, range 84..596.
REQ-007 state  out  2  IDLE=0, PLAY=1, HIT=2, OVER=3.
REQ-008 lives  out  2; score  out  14; hit_pulse  out  1; game_over  out  1.
REQ-009 obs_valid  out  4; obs_x  out  36 (slot i at [9i+8:9i]); obs_y  out  40 (slot i at [10i+9:10i]).

Function
REQ-010 FSM states: IDLE, PLAY, HIT, OVER. IDLE or OVER with start=1 -> PLAY; on that entry lives=LIVES_INIT, score=0, all slots cleared, spawn and hit counters zeroed.
REQ-011 start in PLAY or HIT is ignored; frame_tick in IDLE or OVER is ignored, including when it coincides with start.
REQ-012 All game updates occur only on cycles where frame_tick=1 and state is PLAY or HIT.
REQ-013 Collision, PLAY only: a valid slot hits when |x_ball-x_obs| < BALL_R+OBS_H and |y_ball-y_obs| < BALL_R+OBS_W; use unsigned absolute differences at 10/11-bit width with no wrap; evaluate against pre-tick obstacle positions.
REQ-014 On any hit: hit_pulse=1 for exactly one cycle; lives decrement by 1; all slots invalidated; no score for any slot that tick; no spawn that tick; next state is OVER if lives was 1, otherwise HIT.
REQ-015 No hit in PLAY: every valid slot x_obs increments by 1; a slot whose pre-tick x_obs equals X_MAX becomes invalid instead, and score increases by 1 per such slot, saturating at 16383.
REQ-016 Spawn: spawn counter increments each PLAY tick; when it reaches SPAWN_PERIOD-1 it wraps to 0 and the lowest-index free slot loads x_obs=0 and y_obs=Y_MIN+lfsr[8:0]; if no slot is free the spawn is dropped; slots freed this tick count as free.
REQ-017 LFSR: 9 bits, taps x^9+x^5+1, advances every clk cycle, never reaches zero.
REQ-018 HIT: no collision, no motion, no spawn; hit counter counts frame ticks; after HIT_FRAMES ticks go to PLAY with the spawn counter zeroed.
REQ-019 game_over=1 exactly when state=OVER; lives and score hold in OVER until the next start.
REQ-020 All outputs are registered, with 1-cycle latency from the deciding frame_tick.

Reset
REQ-021 Reset values: state=IDLE, lives=0, score=0, hit_pulse=0, game_over=0, obs_valid=0, obs_x=0, obs_y=0, all counters=0, lfsr=9'h1FF.
REQ-022 Reset asserted mid-game returns to IDLE immediately, with no hit_pulse and no score update.

Structure
REQ-023 A shared package holds the state encoding, Y_MIN/Y_MAX (84/596), X_MAX, and the ball/obstacle size constants used by both this block and the position block.
REQ-024 One sub-module, obstacle_slot (valid/x/y register with move, exit, clear, and load controls), is instantiated four times; the LFSR, counters, and FSM live in the top module.

Verification
REQ-025 Reset, then start=1 for one cycle -> state=PLAY, lives=3, score=0, obs_valid=0.
REQ-026 64 frame ticks, ball at y=84 and obstacle at y>=140 -> slot0 valid with x_obs=0 after tick 64; after 480 further ticks it exits and score=1.
REQ-027 Obstacle at x=100/y=300, ball at x=110/y=330 on a tick -> hit_pulse for 1 cycle, lives=2, obs_valid=0, state=HIT; after 32 ticks state=PLAY.
REQ-028 Three successive hits -> lives=0, state=OVER, game_over=1; next start -> PLAY, lives=3, score=0.
REQ-029 All four slots valid at a spawn tick -> spawn dropped, obs_valid stays 4'hF; a hit on the same tick as a slot exit -> score unchanged.
REQ-030 Reset asserted during HIT -> state=IDLE on the next observation, lfsr=9'h1FF, all outputs at reset values.

Source files
------------

// File: rtl/ball_collision_pkg.sv
// rtl/ball_collision_pkg.sv - shared game constants, state encoding and LFSR step
package ball_collision_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_HIT  = 2'd2,
    ST_OVER = 2'd3
  } game_state_e;

  localparam int C_BALL_R  = 8;
  localparam int C_OBS_H   = 8;
  localparam int C_OBS_W   = 32;
  localparam int C_Y_MIN   = 84;
  localparam int C_Y_MAX   = 596;
  localparam int C_X_MAX   = 479;
  localparam int N_SLOTS   = 4;

  localparam logic [8:0] LFSR_SEED = 9'h1FF;

  // x^9 + x^5 + 1, Fibonacci form; a nonzero seed never reaches zero.
  function automatic logic [8:0] lfsr_next(input logic [8:0] v);
    return {v[7:0], v[8] ^ v[4]};
  endfunction

endpackage

// File: rtl/ball_collision_obstacle_slot.sv
// rtl/ball_collision_obstacle_slot.sv - one obstacle register: valid flag plus x/y position
module obstacle_slot (
  input  logic       clk,
  input  logic       rst_i,
  input  logic       clear_i,
  input  logic       load_i,
  input  logic       move_i,
  input  logic       exit_i,
  input  logic [9:0] load_y_i,
  output logic       valid_o,
  output logic [8:0] x_o,
  output logic [9:0] y_o
);

  logic       valid_q;
  logic [8:0] x_q;
  logic [9:0] y_q;

  // Load beats exit so a slot leaving the field can be reused on the same tick.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      x_q     <= '0;
      y_q     <= load_y_i;
    end else if (exit_i) begin
      valid_q <= 1'b0;
    end else if (move_i && valid_q) begin
      x_q     <= x_q + 9'd1;
    end
  end

  assign valid_o = valid_q;
  assign x_o     = x_q;
  assign y_o     = y_q;

endmodule

// File: rtl/ball_collision.sv
// rtl/ball_collision.sv - game FSM: obstacle spawning, motion, collision, lives and score
module ball_collision
  import ball_collision_pkg::*;
#(
  parameter int BALL_R       = C_BALL_R,
  parameter int OBS_H        = C_OBS_H,
  parameter int OBS_W        = C_OBS_W,
  parameter int Y_MIN        = C_Y_MIN,
  parameter int X_MAX        = C_X_MAX,
  parameter int SPAWN_PERIOD = 64,
  parameter int HIT_FRAMES   = 32,
  parameter int LIVES_INIT   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        frame_tick,
  input  logic [8:0]  x_ball,
  input  logic [9:0]  y_ball,
  output logic [1:0]  state,
  output logic [1:0]  lives,
  output logic [13:0] score,
  output logic        hit_pulse,
  output logic        game_over,
  output logic [3:0]  obs_valid,
  output logic [35:0] obs_x,
  output logic [39:0] obs_y
);

  localparam int SPW = $clog2(SPAWN_PERIOD) + 1;
  localparam int HCW = $clog2(HIT_FRAMES) + 1;

  game_state_e        state_q;
  logic [1:0]         lives_q;
  logic [13:0]        score_q, score_d;
  logic               hit_pulse_q, game_over_q;
  logic [SPW-1:0]     spawn_cnt_q;
  logic [HCW-1:0]     hit_cnt_q;
  logic [8:0]         lfsr_q, lfsr_d;

  logic [N_SLOTS-1:0] slot_valid, hit_vec, exit_vec, free_vec, load_vec, exit_now;
  logic [8:0]         slot_x [N_SLOTS];
  logic [9:0]         slot_y [N_SLOTS];
  logic               start_game, play_tick, hit_any, move_now, spawn_now, clear_all;
  logic [9:0]         spawn_y;
  logic [2:0]         exit_cnt;
  logic [14:0]        score_sum;

  assign start_game = start && (state_q == ST_IDLE || state_q == ST_OVER);
  assign play_tick  = frame_tick && (state_q == ST_PLAY);
  assign hit_any    = play_tick && (|hit_vec);
  assign move_now   = play_tick && !hit_any;
  assign spawn_now  = move_now && (spawn_cnt_q == SPW'(SPAWN_PERIOD - 1));
  assign clear_all  = start_game || hit_any;

  // Exiting slots count as free; isolate the lowest free bit for the spawn.
  assign free_vec = ~slot_valid | exit_vec;
  assign load_vec = spawn_now ? (free_vec & (~free_vec + N_SLOTS'(1))) : '0;
  assign exit_now = move_now ? exit_vec : '0;
  assign spawn_y  = 10'(Y_MIN) + {1'b0, lfsr_q};
  assign lfsr_d   = lfsr_next(lfsr_q);

  for (genvar i = 0; i < N_SLOTS; i++) begin : g_slot
    logic [9:0]  dx;
    logic [10:0] dy;

    assign dx = (x_ball >= slot_x[i]) ? ({1'b0, x_ball} - {1'b0, slot_x[i]})
                                      : ({1'b0, slot_x[i]} - {1'b0, x_ball});
    assign dy = (y_ball >= slot_y[i]) ? ({1'b0, y_ball} - {1'b0, slot_y[i]})
                                      : ({1'b0, slot_y[i]} - {1'b0, y_ball});
    assign hit_vec[i]  = slot_valid[i] && (dx < 10'(BALL_R + OBS_H)) && (dy < 11'(BALL_R + OBS_W));
    assign exit_vec[i] = slot_valid[i] && (slot_x[i] == 9'(X_MAX));

    obstacle_slot u_slot (
      .clk      (clk),
      .rst_i    (reset),
      .clear_i  (clear_all),
      .load_i   (load_vec[i]),
      .move_i   (move_now),
      .exit_i   (exit_now[i]),
      .load_y_i (spawn_y),
      .valid_o  (slot_valid[i]),
      .x_o      (slot_x[i]),
      .y_o      (slot_y[i])
    );

    assign obs_x[9*i +: 9]   = slot_x[i];
    assign obs_y[10*i +: 10] = slot_y[i];
  end

  always_comb begin
    exit_cnt = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      exit_cnt = exit_cnt + {2'b0, exit_now[i]};
    end
  end

  assign score_sum = {1'b0, score_q} + {12'b0, exit_cnt};
  assign score_d   = (score_sum > 15'd16383) ? 14'h3FFF : score_sum[13:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      lives_q     <= '0;
      score_q     <= '0;
      hit_pulse_q <= 1'b0;
      game_over_q <= 1'b0;
      spawn_cnt_q <= '0;
      hit_cnt_q   <= '0;
      lfsr_q      <= LFSR_SEED;
    end else begin
      lfsr_q      <= lfsr_d;
      hit_pulse_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_OVER: begin
          if (start) begin
            state_q     <= ST_PLAY;
            game_over_q <= 1'b0;
            lives_q     <= 2'(LIVES_INIT);
            score_q     <= '0;
            spawn_cnt_q <= '0;
            hit_cnt_q   <= '0;
          end
        end
        ST_PLAY: begin
          if (hit_any) begin
            hit_pulse_q <= 1'b1;
            lives_q     <= lives_q - 2'd1;
            hit_cnt_q   <= '0;
            if (lives_q == 2'd1) begin
              state_q     <= ST_OVER;
              game_over_q <= 1'b1;
            end else begin
              state_q     <= ST_HIT;
            end
          end else if (frame_tick) begin
            score_q     <= score_d;
            spawn_cnt_q <= spawn_now ? '0 : spawn_cnt_q + SPW'(1);
          end
        end
        ST_HIT: begin
          if (frame_tick) begin
            if (hit_cnt_q == HCW'(HIT_FRAMES - 1)) begin
              state_q     <= ST_PLAY;
              hit_cnt_q   <= '0;
              spawn_cnt_q <= '0;
            end else begin
              hit_cnt_q   <= hit_cnt_q + HCW'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign state     = state_q;
  assign lives     = lives_q;
  assign score     = score_q;
  assign hit_pulse = hit_pulse_q;
  assign game_over = game_over_q;
  assign obs_valid = slot_valid;

endmodule

// File: tb/tb_ball_collision.sv
// tb/tb_ball_collision.sv - bench for ball_collision with a behavioural game model
module tb_ball_collision;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        frame_tick = 1'b0;
  logic [8:0]  x_ball = '0;
  logic [9:0]  y_ball = 10'd84;
  logic [1:0]  state;
  logic [1:0]  lives;
  logic [13:0] score;
  logic        hit_pulse;
  logic        game_over;
  logic [3:0]  obs_valid;
  logic [35:0] obs_x;
  logic [39:0] obs_y;

  int checks = 0;
  int failures = 0;

  ball_collision dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .frame_tick (frame_tick),
    .x_ball     (x_ball),
    .y_ball     (y_ball),
    .state      (state),
    .lives      (lives),
    .score      (score),
    .hit_pulse  (hit_pulse),
    .game_over  (game_over),
    .obs_valid  (obs_valid),
    .obs_x      (obs_x),
    .obs_y      (obs_y)
  );

  always #5 clk = ~clk;

  // Game model: plain integer bookkeeping of the rules.
  int m_state = 0, m_lives = 0, m_score = 0, m_hp = 0, m_spawn = 0, m_hitcnt = 0;
  int m_lfsr = 'h1FF;
  int m_v [4];
  int m_x [4];
  int m_y [4];

  function automatic int iabs(input int a);
    return (a < 0) ? -a : a;
  endfunction

  task automatic model_reset();
    m_state = 0; m_lives = 0; m_score = 0; m_hp = 0; m_spawn = 0; m_hitcnt = 0;
    m_lfsr = 'h1FF;
    for (int i = 0; i < 4; i++) begin
      m_v[i] = 0; m_x[i] = 0; m_y[i] = 0;
    end
  endtask

  task automatic model_step();
    int cur, hit, placed;
    cur = m_lfsr;
    m_lfsr = ((m_lfsr << 1) & 'h1FE) | (((m_lfsr >> 8) ^ (m_lfsr >> 4)) & 1);
    m_hp = 0;
    if ((m_state == 0 || m_state == 3) && start) begin
      m_state = 1; m_lives = 3; m_score = 0; m_spawn = 0; m_hitcnt = 0;
      for (int i = 0; i < 4; i++) m_v[i] = 0;
    end else if (frame_tick && m_state == 1) begin
      hit = 0;
      for (int i = 0; i < 4; i++)
        if (m_v[i] != 0 && iabs(int'(x_ball) - m_x[i]) < 16 && iabs(int'(y_ball) - m_y[i]) < 40)
          hit = 1;
      if (hit != 0) begin
        m_hp = 1;
        m_lives = m_lives - 1;
        for (int i = 0; i < 4; i++) m_v[i] = 0;
        m_hitcnt = 0;
        m_state = (m_lives == 0) ? 3 : 2;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (m_v[i] != 0) begin
            if (m_x[i] == 479) begin
              m_v[i] = 0;
              if (m_score < 16383) m_score = m_score + 1;
            end else begin
              m_x[i] = m_x[i] + 1;
            end
          end
        end
        if (m_spawn == 63) begin
          m_spawn = 0;
          placed = 0;
          for (int i = 0; i < 4; i++) begin
            if (placed == 0 && m_v[i] == 0) begin
              m_v[i] = 1; m_x[i] = 0; m_y[i] = 84 + cur; placed = 1;
            end
          end
        end else begin
          m_spawn = m_spawn + 1;
        end
      end
    end else if (frame_tick && m_state == 2) begin
      m_hitcnt = m_hitcnt + 1;
      if (m_hitcnt == 32) begin
        m_state = 1; m_hitcnt = 0; m_spawn = 0;
      end
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else model_step();
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [3:0] ev;
    ev = '0;
    for (int i = 0; i < 4; i++) ev[i] = (m_v[i] != 0);
    chk("m_state", 64'(state), 64'(m_state));
    chk("m_lives", 64'(lives), 64'(m_lives));
    chk("m_score", 64'(score), 64'(m_score));
    chk("m_hit_pulse", 64'(hit_pulse), 64'(m_hp));
    chk("m_game_over", 64'(game_over), 64'(m_state == 3));
    chk("m_obs_valid", 64'(obs_valid), 64'(ev));
    for (int i = 0; i < 4; i++) begin
      if (m_v[i] != 0) begin
        chk("m_obs_x", 64'(obs_x[9*i +: 9]), 64'(m_x[i]));
        chk("m_obs_y", 64'(obs_y[10*i +: 10]), 64'(m_y[i]));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pick_safe_y();
    int ok;
    for (int y = 84; y <= 596; y++) begin
      ok = 1;
      for (int i = 0; i < 4; i++)
        if (m_v[i] != 0 && iabs(y - m_y[i]) < 40) ok = 0;
      if (ok != 0) begin
        y_ball = 10'(y);
        return;
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      x_ball = '0;
      pick_safe_y();
      frame_tick = 1'b1;
      cyc(1);
      frame_tick = 1'b0;
      cyc(1);
    end
  endtask

  task automatic hit_tick(input int s);
    x_ball = 9'(m_x[s] + 10);
    y_ball = (m_y[s] + 30 <= 596) ? 10'(m_y[s] + 30) : 10'(m_y[s] - 30);
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
  endtask

  task automatic start_game();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  initial begin
    cyc(3);
    chk("reset_state", 64'(state), 64'd0);
    chk("reset_lives", 64'(lives), 64'd0);
    chk("reset_obs", 64'({obs_valid, obs_x, obs_y}), 64'd0);
    reset = 1'b0;
    cyc(2);

    start_game();
    chk("start_state", 64'(state), 64'd1);
    chk("start_lives", 64'(lives), 64'd3);
    chk("start_score", 64'(score), 64'd0);
    chk("start_valid", 64'(obs_valid), 64'd0);

    tick(63);
    chk("no_spawn_63", 64'(obs_valid), 64'd0);
    tick(1);
    chk("spawn_64_valid", 64'(obs_valid), 64'h1);
    chk("spawn_64_x", 64'(obs_x[8:0]), 64'd0);

    tick(256);
    chk("full_valid_320", 64'(obs_valid), 64'hF);
    chk("slot0_x_320", 64'(obs_x[8:0]), 64'd256);
    chk("slot3_x_320", 64'(obs_x[35:27]), 64'd64);

    tick(223);
    chk("slot0_x_543", 64'(obs_x[8:0]), 64'd479);
    chk("score_543", 64'(score), 64'd0);
    tick(1);
    chk("score_544", 64'(score), 64'd1);
    chk("exit_valid_544", 64'(obs_valid), 64'hE);

    tick(63);
    chk("slot1_x_607", 64'(obs_x[17:9]), 64'd479);
    hit_tick(2);
    chk("hit1_pulse", 64'(hit_pulse), 64'd1);
    chk("hit1_score_held", 64'(score), 64'd1);
    chk("hit1_lives", 64'(lives), 64'd2);
    chk("hit1_valid", 64'(obs_valid), 64'd0);
    chk("hit1_state", 64'(state), 64'd2);
    cyc(1);
    chk("hit1_pulse_end", 64'(hit_pulse), 64'd0);
    tick(31);
    chk("hit_wait_31", 64'(state), 64'd2);
    tick(1);
    chk("hit_wait_32", 64'(state), 64'd1);

    tick(64);
    chk("respawn_valid", 64'(obs_valid), 64'h1);
    hit_tick(0);
    chk("hit2_lives", 64'(lives), 64'd1);
    chk("hit2_state", 64'(state), 64'd2);
    cyc(1);
    tick(32);
    tick(64);
    hit_tick(0);
    chk("hit3_lives", 64'(lives), 64'd0);
    chk("hit3_state", 64'(state), 64'd3);
    chk("hit3_game_over", 64'(game_over), 64'd1);
    chk("over_score_held", 64'(score), 64'd1);
    cyc(1);
    tick(3);
    chk("over_tick_ignored", 64'(state), 64'd3);

    start = 1'b1;
    frame_tick = 1'b1;
    cyc(1);
    start = 1'b0;
    frame_tick = 1'b0;
    chk("restart_state", 64'(state), 64'd1);
    chk("restart_lives", 64'(lives), 64'd3);
    chk("restart_score", 64'(score), 64'd0);
    cyc(1);
    tick(63);
    chk("restart_no_spawn", 64'(obs_valid), 64'd0);
    tick(1);
    chk("restart_spawn", 64'(obs_valid), 64'h1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("start_in_play_lives", 64'(lives), 64'd3);
    chk("start_in_play_x", 64'(obs_x[8:0]), 64'd1);

    hit_tick(0);
    chk("hit4_state", 64'(state), 64'd2);
    cyc(1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_hit_state", 64'(state), 64'd0);
    chk("rst_hit_lives", 64'(lives), 64'd0);
    chk("rst_hit_score", 64'(score), 64'd0);
    chk("rst_hit_flags", 64'({hit_pulse, game_over}), 64'd0);
    chk("rst_hit_obs", 64'({obs_valid, obs_x, obs_y}), 64'd0);
    cyc(2);
    reset = 1'b0;
    cyc(1);
    start_game();
    tick(64);
    chk("post_rst_spawn", 64'(obs_valid), 64'h1);
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
